// File: rtl/ssd_pkg.sv
// Shared seven-segment display types and constants used by the display arbiter
// and its round-robin picker.
package ssd_pkg;

   localparam int SSD_DIGIT_W = 5;
   localparam int SSD_WORD_W  = 20;

   localparam logic [SSD_DIGIT_W-1:0] SSD_BLANK_DIGIT = 5'b10000;
   localparam logic [SSD_WORD_W-1:0]  SSD_BLANK_WORD  = 20'h84210;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN    = 2'd1,
      SWITCH = 2'd2
   } arb_state_e;

endpackage

// File: rtl/ssd_rr_picker.sv
// Combinational round-robin picker: returns the first requester at or after
// start_i (wrapping modulo NUM_REQ) and whether any requester was found.
module ssd_rr_picker
   import ssd_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [1:0]         start_i,
   output logic [1:0]         win_o,
   output logic               found_o
);

   int idx;

   always_comb begin
      win_o   = 2'd0;
      found_o = 1'b0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(start_i) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found_o && (j == idx) && req_i[j]) begin
               win_o   = 2'(j);
               found_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment scan driver among
// NUM_REQ requesters. Define SSD_ARB_OWNER_DP_EN to light the owner's DP.
module ssd_display_arbiter
   import ssd_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int HOLD_TICKS = 10
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       TICK,
   input  logic [NUM_REQ-1:0]         REQ,
   input  logic [SSD_WORD_W*NUM_REQ-1:0] DATA,
   output logic [NUM_REQ-1:0]         GNT,
   output logic [1:0]                 OWNER,
   output logic                       OWNER_VALID,
   output logic [SSD_WORD_W-1:0]      DISP_WORD
);

   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
   localparam logic [1:0]    LAST_IDX = 2'(NUM_REQ - 1);

`ifdef SSD_ARB_OWNER_DP_EN
   localparam bit OwnerDpEn = 1'b1;
`else
   localparam bit OwnerDpEn = 1'b0;
`endif

   arb_state_e              state_q, state_d;
   logic [1:0]              owner_q, owner_d;
   logic [1:0]              last_q, last_d;
   logic [HW-1:0]           hold_q, hold_d;
   logic [NUM_REQ-1:0]      gnt_q, gnt_d;
   logic [SSD_WORD_W-1:0]   disp_q, disp_d;

   logic [SSD_WORD_W-1:0]   words [4];
   logic [3:0]              req_ext;
   logic [1:0]              start_idx;
   logic [1:0]              win;
   logic                    found;
   logic                    own_req;
   logic                    other_req;

   // Pad to four slots so 2-bit indices never select past the end.
   for (genvar g = 0; g < 4; g++) begin : g_words
      if (g < NUM_REQ) begin : g_real
         assign words[g] = DATA[SSD_WORD_W*g +: SSD_WORD_W];
      end else begin : g_pad
         assign words[g] = SSD_BLANK_WORD;
      end
   end

   assign req_ext   = 4'(REQ);
   assign start_idx = (last_q == LAST_IDX) ? 2'd0 : last_q + 2'd1;
   assign own_req   = req_ext[owner_q];
   assign other_req = (req_ext & ~(4'b0001 << owner_q)) != 4'b0000;

   ssd_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_i   (REQ),
      .start_i (start_idx),
      .win_o   (win),
      .found_o (found)
   );

   function automatic logic [SSD_WORD_W-1:0] owner_word(input logic [SSD_WORD_W-1:0] w,
                                                         input logic [1:0] o);
      logic [SSD_WORD_W-1:0] mask;
      mask = OwnerDpEn ? (20'h00010 << (5 * int'(o))) : '0;
      return w & ~mask;
   endfunction

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      disp_d  = disp_q;
      unique case (state_q)
         IDLE, SWITCH: begin
            hold_d = '0;
            if (found) begin
               state_d = OWN;
               owner_d = win;
               last_d  = win;
               gnt_d   = NUM_REQ'(4'b0001 << win);
               disp_d  = owner_word(words[win], win);
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         OWN: begin
            disp_d = owner_word(words[owner_q], owner_q);
            // Release outranks preemption when both happen together.
            if (!own_req) begin
               state_d = IDLE;
               gnt_d   = '0;
               hold_d  = '0;
            end else if ((hold_q == HOLD_MAX) && other_req) begin
               state_d = SWITCH;
               gnt_d   = '0;
               hold_d  = '0;
            end else if (TICK && (hold_q != HOLD_MAX)) begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         last_q  <= LAST_IDX;
         hold_q  <= '0;
         gnt_q   <= '0;
         disp_q  <= SSD_BLANK_WORD;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         disp_q  <= disp_d;
      end
   end

   assign GNT         = gnt_q;
   assign OWNER       = owner_q;
   assign OWNER_VALID = (state_q == OWN);
   assign DISP_WORD   = disp_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Directed bench for ssd_display_arbiter: a 2-requester instance (hold 3) and
// a 4-requester instance (hold 1) share clock and reset.
module tb_ssd_display_arbiter;

`ifdef SSD_ARB_OWNER_DP_EN
   localparam bit DP_EN = 1'b1;
`else
   localparam bit DP_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;

   logic        tick_a;
   logic [1:0]  req_a;
   logic [39:0] data_a;
   logic [1:0]  gnt_a;
   logic [1:0]  owner_a;
   logic        ov_a;
   logic [19:0] disp_a;

   logic        tick_b;
   logic [3:0]  req_b;
   logic [79:0] data_b;
   logic [3:0]  gnt_b;
   logic [1:0]  owner_b;
   logic        ov_b;
   logic [19:0] disp_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   ssd_display_arbiter #(.NUM_REQ(2), .HOLD_TICKS(3)) u_dut_a (
      .CLK (CLK), .RST (RST), .TICK (tick_a), .REQ (req_a), .DATA (data_a),
      .GNT (gnt_a), .OWNER (owner_a), .OWNER_VALID (ov_a), .DISP_WORD (disp_a)
   );

   ssd_display_arbiter #(.NUM_REQ(4), .HOLD_TICKS(1)) u_dut_b (
      .CLK (CLK), .RST (RST), .TICK (tick_b), .REQ (req_b), .DATA (data_b),
      .GNT (gnt_b), .OWNER (owner_b), .OWNER_VALID (ov_b), .DISP_WORD (disp_b)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Expected word with the owner's decimal point lit in the DP build.
   function automatic logic [19:0] dpw(input logic [19:0] w, input int o);
      logic [19:0] r;
      r = w;
      if (DP_EN) r[5*o+4] = 1'b0;
      return r;
   endfunction

   logic [3:0] exp_gnt [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                4'b0001};
   int         exp_own [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
   logic [19:0] words_b [4] = '{20'h11111, 20'h22222, 20'h84210, 20'h44444};

   initial begin
      RST = 1'b1; tick_a = 1'b0; req_a = 2'b11; data_a = '0;
      tick_b = 1'b0; req_b = 4'b0000; data_b = '0;
      step(); step();
      chk("rst_gnt",   32'(gnt_a),  32'h0);
      chk("rst_ov",    32'(ov_a),   32'h0);
      chk("rst_owner", 32'(owner_a), 32'h0);
      chk("rst_disp",  32'(disp_a), 32'h84210);

      RST = 1'b0; req_a = 2'b00;
      step();
      chk("idle_gnt", 32'(gnt_a), 32'h0);

      // Single requester and data tracking
      data_a = {20'h0ABCD, 20'h00123}; req_a = 2'b01;
      step();
      chk("single_gnt",  32'(gnt_a),  32'h1);
      chk("single_ov",   32'(ov_a),   32'h1);
      chk("single_disp", 32'(disp_a), 32'(dpw(20'h00123, 0)));
      data_a[19:0] = 20'h00456;
      step();
      chk("track_disp", 32'(disp_a), 32'(dpw(20'h00456, 0)));
      req_a = 2'b00;
      step();
      chk("release_gnt",  32'(gnt_a),  32'h0);
      chk("release_ov",   32'(ov_a),   32'h0);
      chk("release_disp", 32'(disp_a), 32'(dpw(20'h00456, 0)));

      // Both request in IDLE: last owner was 0, so requester 1 wins
      req_a = 2'b11;
      step();
      chk("rr_gnt",   32'(gnt_a),   32'h2);
      chk("rr_owner", 32'(owner_a), 32'h1);
      chk("rr_disp",  32'(disp_a),  32'(dpw(20'h0ABCD, 1)));
      req_a = 2'b00;
      step();

      // Preemption after three ticks
      req_a = 2'b01;
      step();
      chk("pre_own0", 32'(gnt_a), 32'h1);
      req_a = 2'b11; tick_a = 1'b1;
      step();
      tick_a = 1'b0;
      step();
      chk("pre_hold1", 32'(gnt_a), 32'h1);
      tick_a = 1'b1;
      step(); step();
      chk("pre_hold3", 32'(gnt_a), 32'h1);
      tick_a = 1'b0;
      step();
      chk("pre_gap_gnt",  32'(gnt_a),  32'h0);
      chk("pre_gap_ov",   32'(ov_a),   32'h0);
      chk("pre_gap_disp", 32'(disp_a), 32'(dpw(20'h00456, 0)));
      step();
      chk("pre_new_gnt",   32'(gnt_a),   32'h2);
      chk("pre_new_owner", 32'(owner_a), 32'h1);
      chk("pre_new_disp",  32'(disp_a),  32'(dpw(20'h0ABCD, 1)));

      // Release on the same cycle the hold is reached: release wins
      tick_a = 1'b1;
      step(); step(); step();
      chk("col_hold_gnt", 32'(gnt_a), 32'h2);
      req_a = 2'b01;
      step();
      chk("col_idle_gnt", 32'(gnt_a), 32'h0);
      chk("col_idle_ov",  32'(ov_a),  32'h0);
      tick_a = 1'b0;
      step();
      chk("col_next_gnt", 32'(gnt_a), 32'h1);
      chk("col_next_ov",  32'(ov_a),  32'h1);

      // Reset while owned
      RST = 1'b1;
      step();
      chk("mid_rst_gnt",   32'(gnt_a),   32'h0);
      chk("mid_rst_ov",    32'(ov_a),    32'h0);
      chk("mid_rst_owner", 32'(owner_a), 32'h0);
      chk("mid_rst_disp",  32'(disp_a),  32'h84210);
      RST = 1'b0; req_a = 2'b00;
      step();

      // Four requesters, all high, hold of one tick
      data_b = {words_b[3], words_b[2], words_b[1], words_b[0]};
      req_b = 4'b1111; tick_b = 1'b1;
      for (int i = 0; i < 13; i++) begin
         step();
         chk($sformatf("fair_gnt%0d", i), 32'(gnt_b), 32'(exp_gnt[i]));
         chk($sformatf("fair_ov%0d", i), 32'(ov_b), (exp_gnt[i] != 4'b0000) ? 32'h1 : 32'h0);
         chk($sformatf("fair_disp%0d", i), 32'(disp_b),
             32'(dpw(words_b[exp_own[i]], exp_own[i])));
         if (exp_gnt[i] != 4'b0000)
            chk($sformatf("fair_owner%0d", i), 32'(owner_b), 32'(exp_own[i]));
      end
      chk("dp_owner2_word", 32'(DP_EN ? 20'h80210 : 20'h84210), 32'(dpw(20'h84210, 2)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
